// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge deck plant model and the DrawBridge controller:
// the 2-bit mechanism state encoding and the default mechanical parameters.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_MOVING_UP   = 2'd1,
    ST_MOVING_DOWN = 2'd2,
    ST_BRAKE       = 2'd3
  } bridge_state_e;

  localparam int unsigned POS_W             = 8;
  localparam int unsigned TRAVEL_DEF        = 16;
  localparam int unsigned STEP_DIV_DEF      = 4;
  localparam int unsigned REVERSE_DWELL_DEF = 2;
  localparam int unsigned STALL_LIMIT_DEF   = 8;

endpackage

// File: rtl/bridge_mechanism_step_prescaler.sv
// Step prescaler: counts enabled clocks and pulses o_tc on the last count of
// each DIV-clock period; i_clr has priority and returns the count to 0.
module step_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;

  // Terminal count is independent of i_clr so a final step can still land on the edge that leaves motion.
  assign o_tc = i_en && (r_count == CW'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/bridge_mechanism.sv
// Cycle-accurate plant model of the bridge deck: motor command in, limit sensors,
// deck position, stall fault and mechanism state out.
module bridge_mechanism
  import bridge_pkg::*;
#(
  parameter int unsigned TRAVEL        = TRAVEL_DEF,
  parameter int unsigned STEP_DIV      = STEP_DIV_DEF,
  parameter int unsigned REVERSE_DWELL = REVERSE_DWELL_DEF,
  parameter int unsigned STALL_LIMIT   = STALL_LIMIT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MT,
  input  logic             DIR,
  input  logic             Jam,
  output logic             H,
  output logic             L,
  output logic [POS_W-1:0] Position,
  output logic             Fault,
  output logic [1:0]       State
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned DW = $clog2(REVERSE_DWELL + 1);

  bridge_state_e    r_state, w_state_next;
  logic [POS_W-1:0] r_pos, w_pos_next;
  logic [SW-1:0]    r_stall, w_stall_next;
  logic [DW-1:0]    r_dwell, w_dwell_next;
  logic             r_fault, w_fault_next;
  logic             r_h, r_l;
  logic             w_moving, w_next_moving, w_tc, w_presc_clr, w_presc_en;

  assign w_moving      = (r_state == ST_MOVING_UP) || (r_state == ST_MOVING_DOWN);
  assign w_next_moving = (w_state_next == ST_MOVING_UP) || (w_state_next == ST_MOVING_DOWN);
  assign w_presc_en    = w_moving && !Jam;
  assign w_presc_clr   = !(w_moving && w_next_moving);

  step_prescaler #(.DIV(STEP_DIV)) u_prescaler (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_clr (w_presc_clr),
    .i_en  (w_presc_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_stall_next = '0;
    w_fault_next = r_fault;
    if (!r_fault && Jam && MT) begin
      if (r_stall == SW'(STALL_LIMIT - 1)) begin
        w_fault_next = 1'b1;
      end else begin
        w_stall_next = r_stall + SW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_stall <= '0;
      r_dwell <= '0;
      r_fault <= 1'b0;
      r_h     <= 1'b0;
      r_l     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      r_stall <= w_stall_next;
      r_dwell <= w_dwell_next;
      r_fault <= w_fault_next;
      r_h     <= (w_pos_next == POS_W'(TRAVEL));
      r_l     <= (w_pos_next == '0);
    end
  end

  // Branch order encodes event priority: fault, jam, limit arrival, motor off, reversal, step.
  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_dwell_next = r_dwell;
    if (w_fault_next) begin
      w_state_next = ST_IDLE;
      w_dwell_next = '0;
    end else if (!Jam) begin
      unique case (r_state)
        ST_IDLE: begin
          if (MT && DIR && (r_pos < POS_W'(TRAVEL))) begin
            w_state_next = ST_MOVING_UP;
          end else if (MT && !DIR && (r_pos != '0)) begin
            w_state_next = ST_MOVING_DOWN;
          end
        end
        ST_MOVING_UP, ST_MOVING_DOWN: begin
          if (w_tc && (r_state == ST_MOVING_UP) && (r_pos == POS_W'(TRAVEL - 1))) begin
            w_pos_next   = POS_W'(TRAVEL);
            w_state_next = ST_IDLE;
          end else if (w_tc && (r_state == ST_MOVING_DOWN) && (r_pos == POS_W'(1))) begin
            w_pos_next   = '0;
            w_state_next = ST_IDLE;
          end else if (!MT) begin
            w_state_next = ST_IDLE;
          end else if (DIR != (r_state == ST_MOVING_UP)) begin
            w_state_next = ST_BRAKE;
            w_dwell_next = '0;
          end else if (w_tc) begin
            w_pos_next = (r_state == ST_MOVING_UP) ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
          end
        end
        ST_BRAKE: begin
          if (r_dwell == DW'(REVERSE_DWELL - 1)) begin
            w_state_next = ST_IDLE;
            w_dwell_next = '0;
          end else begin
            w_dwell_next = r_dwell + DW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    State    = r_state;
    Position = r_pos;
    Fault    = r_fault;
    H        = r_h;
    L        = r_l;
  end

endmodule

// File: doc/bridge_mechanism.md
BRIDGE_MECHANISM -- requirements
Module: bridge_mechanism

Interface
REQ-001 The block SHALL be a cycle-accurate plant model of the bridge deck: it receives the motor command and drives the limit sensors H and L.
REQ-002 Parameters SHALL be, one per line:
  TRAVEL, 16, deck positions from flat (0) to upright (TRAVEL)
  STEP_DIV, 4, clocks per position step while moving
  REVERSE_DWELL, 2, brake cycles on a direction change
  STALL_LIMIT, 8, consecutive jammed motor-on cycles before a fault
REQ-003 Ports SHALL be, one per line:
  Clk  input  1  single clock, rising edge
  Reset  input  1  asynchronous, active-high reset
  MT  input  1  motor enable
  DIR  input  1  direction: 1 raise, 0 lower
  Jam  input  1  fault injection: mechanism blocked
  H  output  1  high limit sensor, 1 when Position==TRAVEL
  L  output  1  low limit sensor, 1 when Position==0
  Position  output  8  deck position, 0..TRAVEL
  Fault  output  1  sticky stall fault
  State  output  2  mechanism state

Function
REQ-004 States SHALL be IDLE=0, MOVING_UP=1, MOVING_DOWN=2, BRAKE=3.
REQ-005 IDLE SHALL transition as follows:
  - MT=1, DIR=1, Position<TRAVEL -> MOVING_UP.
  - MT=1, DIR=0, Position>0 -> MOVING_DOWN.
  - Otherwise IDLE is held, including when a command at a limit would drive past the end.
REQ-006 On entry to a MOVING state the prescaler SHALL be 0.
  - Each following edge in MOVING with Jam=0 increments the prescaler.
  - At prescaler==STEP_DIV-1, Position steps ±1 and the prescaler wraps to 0.
  - The first step therefore lands STEP_DIV edges after entry; full travel takes TRAVEL*STEP_DIV edges.
REQ-007 Position SHALL saturate at 0 and TRAVEL and never wrap; on the edge a limit is reached the state SHALL become IDLE.
REQ-008 MT=0 in a MOVING state SHALL give IDLE on the next edge, clear the prescaler and freeze Position.
REQ-009 A DIR change with MT=1 in a MOVING state SHALL give BRAKE for exactly REVERSE_DWELL edges, then IDLE, with Position frozen. IDLE re-evaluates MT/DIR on the next edge.
REQ-010 H and L SHALL be registered, updated on the same edge as Position, decoded from the next Position value, and never both 1.
REQ-011 Jam=1 SHALL freeze Position and the prescaler in any state.
REQ-012 Jam=1 with MT=1 for STALL_LIMIT consecutive edges SHALL set Fault. The stall counter clears whenever Jam=0 or MT=0.
REQ-013 Once set, Fault SHALL stay set until Reset, force IDLE, and cause MT to be ignored.
REQ-014 Simultaneous events SHALL resolve in this priority order: Reset > Fault > Jam > limit reached > MT=0 > DIR change > step.

Reset
REQ-015 While Reset=1 the block SHALL asynchronously hold: State=IDLE, Position=0, L=1, H=0, Fault=0, and all counters at 0.
REQ-016 Reset asserted mid-motion SHALL return the deck to flat immediately. The first edge after release SHALL evaluate IDLE normally.

Structure
REQ-017 A shared package bridge_pkg SHALL hold the 2-bit state encoding constants and the parameter defaults. The DrawBridge controller SHALL use the same encoding.
REQ-018 One sub-module, step_prescaler, SHALL provide the prescaler (clear, enable, terminal-count pulse). The FSM, Position register, stall counter and BRAKE dwell counter SHALL stay in bridge_mechanism.

Verification
REQ-019 The bench SHALL cover these scenarios with default parameters:
  - Full raise: reset, then MT=1, DIR=1 -> State=1 next edge; L=0 after 4 edges; Position=16 and H=1 after 64 edges, State=0.
  - Full lower from 16: MT=1, DIR=0 -> L=1 and Position=0 after 64 edges; H drops at the first step.
  - Reversal: raise to Position=5, then DIR=0 -> State=3 for 2 edges, then IDLE, then MOVING_DOWN; Position stays 5 throughout the brake.
  - Stall: MT=1, Jam=1 for 8 edges -> Fault=1 and State=0. Dropping Jam does not clear Fault; only Reset does.
  - Limit and pause: MT=1, DIR=0 at Position=0 -> State stays 0. MT pulsed low mid-raise -> Position holds and the prescaler restarts at 0.
  - Reset mid-raise at Position=9 -> Position=0, L=1, State=0 with no clock edge.
